alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning), clock and reset first: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have upstream ports: in_valid  in  1  instruction offered; in_ready  out  1  unit accepts; instr  in  32  RV32I instruction word; rs1_val  in  32  rs1 operand; rs2_val  in  32  rs2 operand.
REQ-003 SHALL have ALU-facing ports: alu_a  out  32; alu_b  out  32; alu_op_code  out  4; alu_out  in  32; alu_zero_flag  in  1; alu_sign_flag  in  1.
REQ-004 SHALL have downstream ports: out_valid  out  1; out_ready  in  1; result  out  32; result_zero  out  1; result_sign  out  1; illegal  out  1  decode failure.
REQ-005 SHALL have err_count  out  8  saturating illegal count, present only under ALU_ISSUE_ERRCNT_EN.

Function
REQ-006 SHALL be a 2-stage pipeline: S1 holds decoded a/b/op_code and drives ALU ports from registers; S2 captures ALU outputs.
REQ-007 Accept SHALL occur when in_valid && in_ready; S1 loads on accept.
REQ-008 in_ready SHALL equal !s1_valid || s2_free, where s2_free = !out_valid || out_ready.
REQ-009 S1 SHALL advance to S2 when s1_valid && s2_free; S2 captures alu_out, alu_zero_flag, alu_sign_flag, illegal bit.
REQ-010 Latency SHALL be 2 cycles accept-to-out_valid with out_ready high; throughput 1/cycle.
REQ-011 result/result_zero/result_sign/illegal SHALL hold stable while out_valid && !out_ready.
REQ-012 R-type (opcode 0110011) SHALL map funct7/funct3: 0000000/000 ADD 0000; 0100000/000 SUB 0001; 0000000/111 AND 0010; /110 OR 0011; /100 XOR 0100; /001 SLL 0101; /101 SRL 0110; 0100000/101 SRA 0111; 0000000/010 SLT 1000; /011 SLTU 1001; alu_a=rs1_val, alu_b=rs2_val.
REQ-013 I-type (opcode 0010011) SHALL use same funct3 mapping, alu_b = sign-extended instr[31:20]; no SUBI.
REQ-014 SLLI/SRLI SHALL require instr[31:25]=0000000; SRAI instr[31:25]=0100000; alu_b = zero-extended instr[24:20].
REQ-015 Any other opcode/funct7 combination SHALL be illegal: alu_op_code=1111, alu_a=alu_b=0, S2 result forced to 0, result_zero=1, result_sign=0, illegal=1.
REQ-016 Simultaneous S2 drain and S1 advance SHALL be lossless; S1 advance and new accept in same cycle SHALL be lossless.
REQ-017 When S1 empty, alu_op_code SHALL be 0000 and alu_a=alu_b=0.

Reset
REQ-018 rst_n low SHALL asynchronously clear s1_valid, out_valid, illegal, result, result_zero, result_sign, alu_a, alu_b, alu_op_code, err_count to 0.
REQ-019 in_ready SHALL be 1 in the first cycle after reset release.
REQ-020 Reset mid-operation SHALL discard all in-flight entries; no out_valid produced for them.

Configuration
REQ-021 Macro ALU_ISSUE_ERRCNT_EN defined: err_count present, increments by 1 each time an illegal entry completes S2 handshake (out_valid && out_ready), saturates at 8'hFF.
REQ-022 Macro ALU_ISSUE_ERRCNT_EN undefined: err_count port and counter absent; all other behaviour identical.

Verification
REQ-023 instr=0x002081B3 (add), rs1=2, rs2=3, out_ready=1 -> alu_op_code=0000, 2 cycles later out_valid=1, result=0x00000005, result_zero=0.
REQ-024 instr=0x402081B3 (sub), rs1=5, rs2=5 -> alu_op_code=0001, result=0, result_zero=1, illegal=0.
REQ-025 instr=0x4040D193 (srai 4), rs1=0x80000000 -> alu_op_code=0111, alu_b=4, result=0xF8000000, result_sign=1.
REQ-026 instr=0xFFF00093 (addi -1), rs1=0 -> alu_b=0xFFFFFFFF, result=0xFFFFFFFF, result_sign=1.
REQ-027 instr=0x0000007F (bad opcode) x2 -> alu_op_code=1111, illegal=1, result=0; with macro err_count=2.
REQ-028 Back-to-back 3 adds, out_ready low 3 cycles -> in_ready drops after 2 held entries, results emerge in order, none lost; rst_n pulse mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Purpose:
//   This is a two-stage issue front-end for an external combinational RV32I
//   ALU.
//   - S1 decodes an accepted instruction into registered operands and an
//     op code. Those registers drive the ALU ports directly.
//   - S2 captures the ALU result and its flags, then presents them on a
//     valid/ready output.
//   Illegal encodings flow through as a bubble. They carry op code 4'hF and
//   a forced zero result, with illegal set.
//
// Optional feature:
//   ALU_ISSUE_ERRCNT_EN adds err_count, an 8-bit saturating count of illegal
//   entries that complete the output handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   instr             RV32I instruction word
//   rs1_val, rs2_val  register operands
//   alu_a, alu_b      operands to the ALU (registered)
//   alu_op_code       ALU operation (registered, 4'hF = illegal)
//   alu_out           ALU result
//   alu_zero_flag     ALU zero flag
//   alu_sign_flag     ALU sign flag
//   out_valid/out_ready downstream handshake
//   result            captured result
//   result_zero       captured zero flag
//   result_sign       captured sign flag
//   illegal           decode failure of the presented entry
//   err_count         saturating illegal count (ALU_ISSUE_ERRCNT_EN only)
// ---------------------------------------------------------------------------
module alu_issue_unit (
  input  logic        clk,
  input  logic        rst_n,
  // upstream
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  // ALU
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op_code,
  input  logic [31:0] alu_out,
  input  logic        alu_zero_flag,
  input  logic        alu_sign_flag,
  // downstream
`ifdef ALU_ISSUE_ERRCNT_EN
  output logic [7:0]  err_count,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        result_zero,
  output logic        result_sign,
  output logic        illegal
);

  // ALU operation encodings
  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;
  localparam logic [3:0] OpIll  = 4'b1111;

  localparam logic [6:0] OpcR = 7'b0110011;
  localparam logic [6:0] OpcI = 7'b0010011;
  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  // -------------------------------------------------------------------------
  // Decode (combinational, on the offered instruction)
  // -------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_sext;
  logic [31:0] w_shamt_zext;

  assign w_opcode     = instr[6:0];
  assign w_funct3     = instr[14:12];
  assign w_funct7     = instr[31:25];
  assign w_imm_sext   = {{20{instr[31]}}, instr[31:20]};
  assign w_shamt_zext = {27'd0, instr[24:20]};

  // Register-specifier fields are resolved upstream; only the operand values matter here.
  logic w_unused_fields;
  assign w_unused_fields = ^{instr[19:15], instr[11:7]};

  logic [3:0]  w_dec_op;
  logic [31:0] w_dec_a;
  logic [31:0] w_dec_b;
  logic        w_dec_illegal;

  always_comb begin
    w_dec_op      = OpIll;
    w_dec_a       = 32'd0;
    w_dec_b       = 32'd0;
    w_dec_illegal = 1'b1;

    if (w_opcode == OpcR) begin
      if (w_funct7 == F7Zero) begin
        w_dec_illegal = 1'b0;
        unique case (w_funct3)
          3'b000:  w_dec_op = OpAdd;
          3'b111:  w_dec_op = OpAnd;
          3'b110:  w_dec_op = OpOr;
          3'b100:  w_dec_op = OpXor;
          3'b001:  w_dec_op = OpSll;
          3'b101:  w_dec_op = OpSrl;
          3'b010:  w_dec_op = OpSlt;
          3'b011:  w_dec_op = OpSltu;
          default: w_dec_illegal = 1'b1;
        endcase
      end else if (w_funct7 == F7Alt) begin
        if (w_funct3 == 3'b000) begin
          w_dec_op      = OpSub;
          w_dec_illegal = 1'b0;
        end else if (w_funct3 == 3'b101) begin
          w_dec_op      = OpSra;
          w_dec_illegal = 1'b0;
        end
      end
      if (!w_dec_illegal) begin
        w_dec_a = rs1_val;
        w_dec_b = rs2_val;
      end
    end else if (w_opcode == OpcI) begin
      w_dec_b       = w_imm_sext;
      w_dec_illegal = 1'b0;
      unique case (w_funct3)
        3'b000: w_dec_op = OpAdd;
        3'b111: w_dec_op = OpAnd;
        3'b110: w_dec_op = OpOr;
        3'b100: w_dec_op = OpXor;
        3'b010: w_dec_op = OpSlt;
        3'b011: w_dec_op = OpSltu;
        3'b001: begin
          w_dec_b = w_shamt_zext;
          if (w_funct7 == F7Zero) w_dec_op = OpSll;
          else                    w_dec_illegal = 1'b1;
        end
        3'b101: begin
          w_dec_b = w_shamt_zext;
          if (w_funct7 == F7Zero)     w_dec_op = OpSrl;
          else if (w_funct7 == F7Alt) w_dec_op = OpSra;
          else                        w_dec_illegal = 1'b1;
        end
        default: w_dec_illegal = 1'b1;
      endcase
      if (w_dec_illegal) begin
        w_dec_b = 32'd0;
      end else begin
        w_dec_a = rs1_val;
      end
    end

    if (w_dec_illegal) w_dec_op = OpIll;
  end

  // -------------------------------------------------------------------------
  // Pipeline control
  // -------------------------------------------------------------------------
  logic        r_s1_valid;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_op;
  logic        r_s1_illegal;

  logic        r_out_valid;
  logic [31:0] r_result;
  logic        r_result_zero;
  logic        r_result_sign;
  logic        r_illegal;

  logic w_s2_free;
  logic w_accept;
  logic w_advance;
  logic w_out_fire;

  assign w_s2_free  = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_accept   = in_valid && in_ready;
  assign w_advance  = r_s1_valid && w_s2_free;
  assign w_out_fire = r_out_valid && out_ready;

  // S1 next state. An accept overrides the advance, because the slot empties
  // and refills in the same cycle. A lone advance returns the ALU ports to
  // their idle (all-zero) drive.
  logic        w_s1_valid_nxt;
  logic [31:0] w_alu_a_nxt;
  logic [31:0] w_alu_b_nxt;
  logic [3:0]  w_alu_op_nxt;
  logic        w_s1_illegal_nxt;

  always_comb begin
    w_s1_valid_nxt   = r_s1_valid;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_op_nxt     = r_alu_op;
    w_s1_illegal_nxt = r_s1_illegal;
    if (w_accept) begin
      w_s1_valid_nxt   = 1'b1;
      w_alu_a_nxt      = w_dec_a;
      w_alu_b_nxt      = w_dec_b;
      w_alu_op_nxt     = w_dec_op;
      w_s1_illegal_nxt = w_dec_illegal;
    end else if (w_advance) begin
      w_s1_valid_nxt   = 1'b0;
      w_alu_a_nxt      = 32'd0;
      w_alu_b_nxt      = 32'd0;
      w_alu_op_nxt     = OpAdd;
      w_s1_illegal_nxt = 1'b0;
    end
  end

  // S2 next state. Outputs only change on a capture, so they hold while stalled.
  logic        w_out_valid_nxt;
  logic [31:0] w_result_nxt;
  logic        w_result_zero_nxt;
  logic        w_result_sign_nxt;
  logic        w_illegal_nxt;

  always_comb begin
    w_out_valid_nxt   = r_out_valid;
    w_result_nxt      = r_result;
    w_result_zero_nxt = r_result_zero;
    w_result_sign_nxt = r_result_sign;
    w_illegal_nxt     = r_illegal;
    if (w_advance) begin
      w_out_valid_nxt = 1'b1;
      w_illegal_nxt   = r_s1_illegal;
      if (r_s1_illegal) begin
        // Ignore whatever the ALU returns for the illegal op code.
        w_result_nxt      = 32'd0;
        w_result_zero_nxt = 1'b1;
        w_result_sign_nxt = 1'b0;
      end else begin
        w_result_nxt      = alu_out;
        w_result_zero_nxt = alu_zero_flag;
        w_result_sign_nxt = alu_sign_flag;
      end
    end else if (w_out_fire) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_alu_a       <= 32'd0;
      r_alu_b       <= 32'd0;
      r_alu_op      <= OpAdd;
      r_s1_illegal  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_result      <= 32'd0;
      r_result_zero <= 1'b0;
      r_result_sign <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_s1_valid    <= w_s1_valid_nxt;
      r_alu_a       <= w_alu_a_nxt;
      r_alu_b       <= w_alu_b_nxt;
      r_alu_op      <= w_alu_op_nxt;
      r_s1_illegal  <= w_s1_illegal_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_result      <= w_result_nxt;
      r_result_zero <= w_result_zero_nxt;
      r_result_sign <= w_result_sign_nxt;
      r_illegal     <= w_illegal_nxt;
    end
  end

`ifdef ALU_ISSUE_ERRCNT_EN
  logic [7:0] r_err_count;
  logic       w_err_inc;

  assign w_err_inc = w_out_fire && r_illegal && (r_err_count != 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 8'd0;
    end else if (w_err_inc) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op_code = r_alu_op;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign result_zero = r_result_zero;
  assign result_sign = r_result_sign;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed testbench for alu_issue_unit. A behavioural ALU answers the
// DUT's ALU ports, and every expected value below is hand-computed.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op_code;
  logic [31:0] alu_out;
  logic        alu_zero_flag;
  logic        alu_sign_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        result_zero;
  logic        result_sign;
  logic        illegal;
`ifdef ALU_ISSUE_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_checks;
  int n_errors;

  alu_issue_unit u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op_code   (alu_op_code),
    .alu_out       (alu_out),
    .alu_zero_flag (alu_zero_flag),
    .alu_sign_flag (alu_sign_flag),
`ifdef ALU_ISSUE_ERRCNT_EN
    .err_count     (err_count),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .result_zero   (result_zero),
    .result_sign   (result_sign),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stand-in
  always_comb begin
    alu_out = 32'd0;
    case (alu_op_code)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = alu_a ^ alu_b;
      4'd5: alu_out = alu_a << alu_b[4:0];
      4'd6: alu_out = alu_a >> alu_b[4:0];
      4'd7: alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
      4'd8: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd9: alu_out = {31'd0, alu_a < alu_b};
      default: alu_out = 32'hDEADBEEF;
    endcase
    alu_zero_flag = (alu_out == 32'd0);
    alu_sign_flag = alu_out[31];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = i;
    rs1_val  = a;
    rs2_val  = b;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'd0;
    rs1_val   = 32'd0;
    rs2_val   = 32'd0;
    out_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    step();

    // Reset state
    check_eq("rst_in_ready",  32'(in_ready),    32'd1);
    check_eq("rst_out_valid", 32'(out_valid),   32'd0);
    check_eq("rst_alu_op",    32'(alu_op_code), 32'd0);
    check_eq("rst_alu_a",     alu_a,            32'd0);
    check_eq("rst_result",    result,           32'd0);
    check_eq("rst_illegal",   32'(illegal),     32'd0);

    // add 2+3
    offer(32'h002081B3, 32'd2, 32'd3);
    step();
    in_valid = 1'b0;
    check_eq("add_op",    32'(alu_op_code), 32'h0);
    check_eq("add_a",     alu_a,            32'd2);
    check_eq("add_b",     alu_b,            32'd3);
    check_eq("add_ov_s1", 32'(out_valid),   32'd0);
    step();
    check_eq("add_ov",      32'(out_valid),   32'd1);
    check_eq("add_res",     result,           32'd5);
    check_eq("add_zero",    32'(result_zero), 32'd0);
    check_eq("idle_alu_op", 32'(alu_op_code), 32'd0);
    check_eq("idle_alu_b",  alu_b,            32'd0);

    // sub 5-5
    offer(32'h402081B3, 32'd5, 32'd5);
    step();
    in_valid = 1'b0;
    check_eq("sub_op", 32'(alu_op_code), 32'h1);
    step();
    check_eq("sub_res",  result,           32'd0);
    check_eq("sub_zero", 32'(result_zero), 32'd1);
    check_eq("sub_ill",  32'(illegal),     32'd0);

    // srai 4
    offer(32'h4040D193, 32'h80000000, 32'd0);
    step();
    in_valid = 1'b0;
    check_eq("srai_op", 32'(alu_op_code), 32'h7);
    check_eq("srai_b",  alu_b,            32'd4);
    step();
    check_eq("srai_res",  result,           32'hF8000000);
    check_eq("srai_sign", 32'(result_sign), 32'd1);

    // addi -1
    offer(32'hFFF00093, 32'd0, 32'd0);
    step();
    in_valid = 1'b0;
    check_eq("addi_b", alu_b, 32'hFFFFFFFF);
    step();
    check_eq("addi_res",  result,           32'hFFFFFFFF);
    check_eq("addi_sign", 32'(result_sign), 32'd1);

    // Two illegal opcodes back to back
    offer(32'h0000007F, 32'h1234, 32'h5678);
    step();
    check_eq("ill_op", 32'(alu_op_code), 32'hF);
    check_eq("ill_a",  alu_a,            32'd0);
    check_eq("ill_b",  alu_b,            32'd0);
    step();
    in_valid = 1'b0;
    check_eq("ill1_ov",   32'(out_valid),   32'd1);
    check_eq("ill1_flag", 32'(illegal),     32'd1);
    check_eq("ill1_res",  result,           32'd0);
    check_eq("ill1_zero", 32'(result_zero), 32'd1);
    check_eq("ill1_sign", 32'(result_sign), 32'd0);
    step();
    check_eq("ill2_ov",   32'(out_valid), 32'd1);
    check_eq("ill2_flag", 32'(illegal),   32'd1);
    step();
    check_eq("ill_drain", 32'(out_valid), 32'd0);
`ifdef ALU_ISSUE_ERRCNT_EN
    check_eq("err_count", 32'(err_count), 32'd2);
`endif

    // Back-to-back adds with output stalled
    out_ready = 1'b0;
    offer(32'h002081B3, 32'd1, 32'd1);
    step();
    check_eq("bp_rdy1", 32'(in_ready), 32'd1);
    offer(32'h002081B3, 32'd10, 32'd20);
    step();
    check_eq("bp_ov1",   32'(out_valid), 32'd1);
    check_eq("bp_res1",  result,         32'd2);
    check_eq("bp_rdy0",  32'(in_ready),  32'd0);
    offer(32'h002081B3, 32'd100, 32'd200);
    step();
    check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);
    check_eq("bp_hold_res", result,        32'd2);
    step();
    check_eq("bp_hold_res2", result,         32'd2);
    check_eq("bp_hold_ov",   32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check_eq("bp_rdy_rel", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("bp_res2", result, 32'd30);
    step();
    check_eq("bp_res3", result,         32'd300);
    check_eq("bp_ov3",  32'(out_valid), 32'd1);
    step();
    check_eq("bp_empty", 32'(out_valid), 32'd0);

    // Reset with both stages occupied
    offer(32'h002081B3, 32'd7, 32'd7);
    step();
    out_ready = 1'b0;
    offer(32'h002081B3, 32'd8, 32'd8);
    step();
    in_valid = 1'b0;
    check_eq("mr_full_ov", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    check_eq("mr_async_ov", 32'(out_valid), 32'd0);
    check_eq("mr_async_a",  alu_a,          32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check_eq("mr_ov",  32'(out_valid),   32'd0);
    check_eq("mr_rdy", 32'(in_ready),    32'd1);
    check_eq("mr_op",  32'(alu_op_code), 32'd0);
    step();
    check_eq("mr_ghost", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
